// File: rtl/c5g_pio_master_seq.sv
// c5g_pio_master_seq: Avalon-MM initiator that writes one value to a PIO-style
// slave register, reads it back and reports mismatch or waitrequest timeout.
// Every output is a register. The FSM computes the next value of each output
// together with the next state, so all outputs change on the same edge as the
// state.
module c5g_pio_master_seq #(
  parameter int DATA_W       = 10,
  parameter int ADDR_W       = 2,
  parameter int TARGET_ADDR  = 0,
  parameter int READ_LATENCY = 0,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              mismatch,
  output logic              timeout,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [1:0] LAT = 2'(READ_LATENCY);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    RD_WAIT = 3'd3,
    FIN     = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] wr_lat, wr_lat_n;
  logic [TO_W-1:0]   to_cnt, to_cnt_n;
  logic [1:0]        lat_cnt, lat_cnt_n;
  logic              busy_n, done_n, mismatch_n, timeout_n;
  logic [DATA_W-1:0] rd_data_n;
  logic [ADDR_W-1:0] addr_n;
  logic              cs_n, write_n_n;
  logic [31:0]       wdata_n;
  logic              accepted, expired;

  // Only the low DATA_W readdata bits carry meaning.
  logic unused_readdata_hi;
  assign unused_readdata_hi = ^avm_readdata;

  // Transfer handshake and waitrequest budget for the current WR/RD phase.
  always_comb begin
    accepted = avm_chipselect && !avm_waitrequest;
    expired  = avm_chipselect && avm_waitrequest && (to_cnt == TO_LAST);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    wr_lat_n   = wr_lat;
    to_cnt_n   = to_cnt;
    lat_cnt_n  = lat_cnt;
    busy_n     = busy;
    done_n     = 1'b0;
    mismatch_n = mismatch;
    timeout_n  = timeout;
    rd_data_n  = rd_data;
    addr_n     = avm_address;
    cs_n       = avm_chipselect;
    write_n_n  = avm_write_n;
    wdata_n    = avm_writedata;

    case (state)
      IDLE: begin
        if (start) begin
          state_n             = WR;
          wr_lat_n            = wr_data;
          mismatch_n          = 1'b0;
          timeout_n           = 1'b0;
          busy_n              = 1'b1;
          to_cnt_n            = '0;
          cs_n                = 1'b1;
          write_n_n           = 1'b0;
          addr_n              = ADDR_W'(TARGET_ADDR);
          wdata_n             = '0;
          wdata_n[DATA_W-1:0] = wr_data;
        end
      end

      WR: begin
        if (accepted) begin
          state_n   = RD;
          to_cnt_n  = '0;
          write_n_n = 1'b1;
          wdata_n   = '0;
        end else if (expired) begin
          state_n    = FIN;
          done_n     = 1'b1;
          timeout_n  = 1'b1;
          mismatch_n = 1'b0;
          cs_n       = 1'b0;
          write_n_n  = 1'b1;
          addr_n     = '0;
          wdata_n    = '0;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end

      RD: begin
        if (accepted) begin
          cs_n   = 1'b0;
          addr_n = '0;
          if (READ_LATENCY == 0) begin
            state_n    = FIN;
            done_n     = 1'b1;
            rd_data_n  = avm_readdata[DATA_W-1:0];
            mismatch_n = (avm_readdata[DATA_W-1:0] != wr_lat);
          end else begin
            state_n   = RD_WAIT;
            lat_cnt_n = 2'd1;
          end
        end else if (expired) begin
          state_n    = FIN;
          done_n     = 1'b1;
          timeout_n  = 1'b1;
          mismatch_n = 1'b0;
          cs_n       = 1'b0;
          addr_n     = '0;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end

      // Mismatch is judged against the live bus value on the capture edge so
      // that it is already valid in the cycle done is high.
      RD_WAIT: begin
        if (lat_cnt == LAT) begin
          state_n    = FIN;
          done_n     = 1'b1;
          lat_cnt_n  = '0;
          rd_data_n  = avm_readdata[DATA_W-1:0];
          mismatch_n = (avm_readdata[DATA_W-1:0] != wr_lat);
        end else begin
          lat_cnt_n = lat_cnt + 1'b1;
        end
      end

      FIN: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end

      default: begin
        state_n   = IDLE;
        busy_n    = 1'b0;
        cs_n      = 1'b0;
        write_n_n = 1'b1;
        addr_n    = '0;
        wdata_n   = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      wr_lat         <= '0;
      to_cnt         <= '0;
      lat_cnt        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      mismatch       <= 1'b0;
      timeout        <= 1'b0;
      rd_data        <= '0;
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
    end else begin
      state          <= state_n;
      wr_lat         <= wr_lat_n;
      to_cnt         <= to_cnt_n;
      lat_cnt        <= lat_cnt_n;
      busy           <= busy_n;
      done           <= done_n;
      mismatch       <= mismatch_n;
      timeout        <= timeout_n;
      rd_data        <= rd_data_n;
      avm_address    <= addr_n;
      avm_chipselect <= cs_n;
      avm_write_n    <= write_n_n;
      avm_writedata  <= wdata_n;
    end
  end

endmodule
